// File: rtl/scg_auto_ref.sv
// ============================================================================
// scg_auto_ref
// ----------------------------------------------------------------------------
// SDRAM command-sequence generator for one auto-refresh operation.
//
// A level-sensitive start request produces exactly one AUTO REFRESH command,
// followed by NOP cycles while tRFC elapses. Then done is raised and held
// until the requester drops start. A request that is still held once done
// is reached therefore cannot trigger a second refresh.
//
// Optional feature (compile-time macro SCG_AUTO_REF_PRECHARGE_EN):
//   When defined, a PRECHARGE ALL command and one tRP NOP cycle are issued
//   before the AUTO REFRESH. The start-to-REFRESH latency becomes 3 cycles.
//   The timing from REFRESH to done does not change.
//   When undefined, there is no precharge step.
//
// Parameters:
//   TRFC_CYCLES   : cycles from the REFRESH cycle to the first done=1 cycle
//                   (must be 2 or more)
//   CMD_NOP       : NOP command code
//   CMD_REFRESH   : AUTO REFRESH command code
//   CMD_PRECHARGE : PRECHARGE ALL command code (only with the macro defined)
//
// Ports:
//   clk         in   system clock, rising-edge active
//   n_rst       in   synchronous reset, ACTIVE-HIGH despite its name
//   start       in   refresh request (level)
//   done        out  sequence complete; held while start stays high
//   command     out  4-bit SDRAM command code
//   o_dbg_state out  current FSM state, for observation only
//                    (IDLE=0, REF=1, WAIT=2, DONE=3, PRECH=4, TRP=5)
//
// Handshake: start is a level request. The block samples it only in IDLE,
// where it starts a sequence, and in DONE, where start=0 releases the block
// back to IDLE. In every other state start is ignored. done stays high for
// as long as start stays high in DONE.
//
// All outputs are Moore-decoded from the state register. There is no
// combinational path from start to done or command.
// ============================================================================
module scg_auto_ref #(
    parameter int          TRFC_CYCLES   = 10,
    parameter logic [3:0]  CMD_NOP       = 4'd0,
    parameter logic [3:0]  CMD_REFRESH   = 4'd5
`ifdef SCG_AUTO_REF_PRECHARGE_EN
    ,
    parameter logic [3:0]  CMD_PRECHARGE = 4'd2
`endif
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    output logic       done,
    output logic [3:0] command,
    output logic [2:0] o_dbg_state
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    // The REF cycle and at least one WAIT cycle are needed to reach done, so
    // a tRFC below 2 cannot be represented by this sequence.
    if (TRFC_CYCLES < 2) begin : g_bad_trfc
        $error("scg_auto_ref: TRFC_CYCLES must be 2 or more");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REF   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
`ifdef SCG_AUTO_REF_PRECHARGE_EN
    localparam logic [2:0] ST_PRECH = 3'd4;
    localparam logic [2:0] ST_TRP   = 3'd5;
`endif

    // ------------------------------------------------------------------------
    // Counter sizing
    // ------------------------------------------------------------------------
    // The counter is loaded with TRFC_CYCLES-2 in REF and counts down to 0
    // in WAIT. That gives TRFC_CYCLES-1 WAIT cycles, so the first DONE cycle
    // comes exactly TRFC_CYCLES cycles after the REFRESH cycle. The counter
    // is reloaded on every REF, so it never wraps.
    localparam int         CW      = $clog2(TRFC_CYCLES);
    localparam logic [CW-1:0] W_LOAD = CW'(TRFC_CYCLES - 2);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [CW-1:0] r_counter;
    logic          w_count_zero;

    assign w_count_zero = (r_counter == '0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef SCG_AUTO_REF_PRECHARGE_EN
                    w_next_state = ST_PRECH;
`else
                    w_next_state = ST_REF;
`endif
                end
            end
`ifdef SCG_AUTO_REF_PRECHARGE_EN
            // One PRECHARGE ALL cycle, then one NOP cycle to cover tRP.
            ST_PRECH: w_next_state = ST_TRP;
            ST_TRP:   w_next_state = ST_REF;
`endif
            ST_REF:   w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_count_zero) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // A held request keeps the block here, so the same request
                // cannot trigger a second refresh.
                if (!start) begin
                    w_next_state = ST_IDLE;
                end
            end
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst) begin
            // Reset aborts any sequence in progress. IDLE issues only NOPs,
            // so no further REFRESH can follow.
            r_state   <= ST_IDLE;
            r_counter <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_REF:  r_counter <= W_LOAD;
                ST_WAIT: begin
                    if (!w_count_zero) begin
                        r_counter <= r_counter - 1'b1;
                    end
                end
                default: r_counter <= r_counter;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        command = CMD_NOP;
        done    = 1'b0;
        case (r_state)
            ST_REF:   command = CMD_REFRESH;
`ifdef SCG_AUTO_REF_PRECHARGE_EN
            ST_PRECH: command = CMD_PRECHARGE;
`endif
            ST_DONE:  done    = 1'b1;
            default: begin
                command = CMD_NOP;
                done    = 1'b0;
            end
        endcase
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_scg_auto_ref.sv
// ============================================================================
// tb_scg_auto_ref
// ----------------------------------------------------------------------------
// Directed bench for scg_auto_ref with the default parameters
// (TRFC_CYCLES=10, NOP=0, REFRESH=5, PRECHARGE=2).
//
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at the same point, which is away from the active edge.
// If SCG_AUTO_REF_PRECHARGE_EN is defined, the bench expects 2, 0 before
// each REFRESH.
// ============================================================================
module tb_scg_auto_ref;

    localparam int TRFC = 10;
`ifdef SCG_AUTO_REF_PRECHARGE_EN
    localparam int PRE_CYCLES = 2;
`else
    localparam int PRE_CYCLES = 0;
`endif

    localparam logic [2:0] IDLE_ST = 3'd0;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       done;
    logic [3:0] command;
    logic [2:0] dbg_state;

    int errors;
    int checks;
    int cycle;
    int ref_cycle;
    int prev_ref_cycle;

    scg_auto_ref u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .done        (done),
        .command     (command),
        .o_dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one refresh sequence. Preconditions: the DUT is in IDLE and start
    // has just been set to 1, with no edge taken yet. The task returns in
    // the first DONE cycle, with start still as the caller left it or 0 if
    // drop_early was set.
    task automatic run_sequence(input string tag, input bit drop_early);
        // The cycle in which start rises still shows NOP.
        check({tag, "_cmd_start_cycle"}, command, 4'd0);
        tick();
        if (drop_early) start = 1'b0;
`ifdef SCG_AUTO_REF_PRECHARGE_EN
        check({tag, "_cmd_prech"}, command, 4'd2);
        tick();
        check({tag, "_cmd_trp"}, command, 4'd0);
        tick();
`endif
        check({tag, "_cmd_refresh"}, command, 4'd5);
        check({tag, "_done_refresh"}, {3'b0, done}, 4'd0);
        prev_ref_cycle = ref_cycle;
        ref_cycle      = cycle;
        for (int i = 1; i <= TRFC; i++) begin
            tick();
            check({tag, "_cmd_wait"}, command, 4'd0);
            check({tag, "_done_wait"}, {3'b0, done}, (i == TRFC) ? 4'd1 : 4'd0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    initial begin
        errors         = 0;
        checks         = 0;
        cycle          = 0;
        ref_cycle      = 0;
        prev_ref_cycle = 0;
        n_rst          = 1'b1;
        start          = 1'b0;

        // Reset
        tick();
        check("rst_cmd",   command,           4'd0);
        check("rst_done",  {3'b0, done},      4'd0);
        check("rst_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});
        n_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_cmd",   command,           4'd0);
            check("idle_done",  {3'b0, done},      4'd0);
            check("idle_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});
        end

        // Single refresh
        start = 1'b1;
        run_sequence("single", 1'b0);

        // Handshake: a held start keeps done high, with no second REFRESH
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_cmd",  command,      4'd0);
            check("hold_done", {3'b0, done}, 4'd1);
        end
        start = 1'b0;
        tick();
        check("release_done",  {3'b0, done},      4'd0);
        check("release_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});

        // Back-to-back at the minimum gap
        start = 1'b1;
        run_sequence("b2b_a", 1'b0);
        start = 1'b0;
        tick();
        check("b2b_gap_idle", {1'b0, dbg_state}, {1'b0, IDLE_ST});
        start = 1'b1;
        run_sequence("b2b_b", 1'b0);
        check_int("b2b_min_gap", ref_cycle - prev_ref_cycle, TRFC + 2 + PRE_CYCLES);
        start = 1'b0;
        tick();
        check("b2b_end_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});

        // Abort: reset on the 4th cycle after REFRESH
        start = 1'b1;
        for (int i = 0; i <= PRE_CYCLES; i++) tick();
        check("abort_cmd_refresh", command, 4'd5);
        for (int i = 0; i < 3; i++) tick();
        check("abort_cmd_wait", command, 4'd0);
        n_rst = 1'b1;
        start = 1'b0;
        tick();
        check("abort_cmd",   command,           4'd0);
        check("abort_done",  {3'b0, done},      4'd0);
        check("abort_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});
        n_rst = 1'b0;
        for (int i = 0; i < TRFC + 2; i++) begin
            tick();
            check("post_abort_cmd",  command,      4'd0);
            check("post_abort_done", {3'b0, done}, 4'd0);
        end
        start = 1'b1;
        run_sequence("restart", 1'b0);
        start = 1'b0;
        tick();
        check("restart_end_state", {1'b0, dbg_state}, {1'b0, IDLE_ST});

        // Early drop: start lasts one cycle, done pulses for one cycle
        start = 1'b1;
        run_sequence("early", 1'b1);
        tick();
        check("early_done_pulse", {3'b0, done},      4'd0);
        check("early_state",      {1'b0, dbg_state}, {1'b0, IDLE_ST});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("early_idle_cmd", command, 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
